// File: rtl/mar_burst.sv
// Memory address register with load/hold, single-step increment and a
// valid/ready burst generator stepping by a stride inside a mask-defined wrap window.
module mar_burst #(
  parameter int AW = 16,
  parameter int LW = 8,
  parameter int SW = 4
) (
  input  logic          MARB_clk,
  input  logic          MARB_rst,
  input  logic [AW-1:0] MARB_in,
  input  logic          MARB_we,
  input  logic          MARB_inc,
  input  logic [SW-1:0] MARB_stride,
  input  logic [AW-1:0] MARB_mask,
  input  logic          MARB_start,
  input  logic [LW-1:0] MARB_len,
  input  logic          MARB_ready,
  output logic [AW-1:0] MARB_out,
  output logic          MARB_valid,
  output logic          MARB_done
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] stride_q, stride_d;
  logic [AW-1:0] mask_q, mask_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Masked bits take the stepped value, unmasked bits keep the current address.
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a,
                                         input logic [SW-1:0] s,
                                         input logic [AW-1:0] m);
    logic [AW-1:0] sum;
    sum = a + AW'(s);
    return (a & ~m) | (sum & m);
  endfunction

  always_ff @(posedge MARB_clk) begin
    if (MARB_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MARB_we) begin
          addr_d = MARB_in;
        end else if (MARB_start && (MARB_len != '0)) begin
          stride_d = MARB_stride;
          mask_d   = MARB_mask;
          cnt_d    = MARB_len;
          state_d  = S_BURST;
        end else if (MARB_inc) begin
          addr_d = adv(addr_q, MARB_stride, MARB_mask);
        end
      end
      S_BURST: begin
        if (MARB_we) begin
          // Abort: reload and drop the burst without a done pulse.
          addr_d  = MARB_in;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (MARB_ready) begin
          addr_d = adv(addr_q, stride_q, mask_q);
          cnt_d  = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MARB_out   = addr_q;
    MARB_valid = (state_q == S_BURST);
    MARB_done  = done_q;
  end

endmodule

// File: doc/mar_burst.md
# mar_burst

Parametrised memory address register with a burst address generator. It keeps the load/hold behaviour of the basic address register and adds single-step increment, a programmable stride, a wrap window defined by a mask, and a valid/ready burst mode that emits a sequence of addresses to the memory interface. It sits between the control unit, which loads, increments or starts bursts, and the memory port, which consumes addresses.

## Interface
Parameters:
- AW, 16, address width
- LW, 8, burst length counter width
- SW, 4, stride width (zero-extended to AW)

Ports:
- MARB_clk  in  1  clock; all state updates on the rising edge
- MARB_rst  in  1  reset; synchronous, active-high
- MARB_in  in  AW  load value
- MARB_we  in  1  load MARB_in into the address register
- MARB_inc  in  1  single-step advance (IDLE only)
- MARB_stride  in  SW  step size
- MARB_mask  in  AW  wrap mask; set bits advance, clear bits are held
- MARB_start  in  1  start a burst (IDLE only)
- MARB_len  in  LW  burst beat count; 0 = start ignored
- MARB_ready  in  1  consumer accepts the current address
- MARB_out  out  AW  current address
- MARB_valid  out  1  high in BURST; MARB_out is a burst beat
- MARB_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Advance function: next(a, s, m) = (a & ~m) | ((a + zext(s)) & m), with the sum truncated to AW bits.
  - m = all ones gives linear modulo-2^AW stepping.
  - m = 0 leaves the address frozen.
- States: IDLE and BURST.
- Priority each cycle: rst > we > start > inc.
- IDLE:
  - we: out <= MARB_in.
  - else start with len != 0: latch stride, mask and len into internal registers; go to BURST; out unchanged.
  - else inc: out <= next(out, MARB_stride, MARB_mask), using the live inputs.
  - else hold.
- BURST:
  - valid = 1.
  - On valid && ready: out <= next(out, latched stride, latched mask) and the beat counter decrements.
    - If this was the last beat (counter == 1): go to IDLE and pulse done on the following cycle.
  - The address advances after every beat, including the last, so after a burst out points one stride past the final beat (post-increment pointer).
  - start and inc are ignored in BURST.
  - Live changes to MARB_stride, MARB_mask or MARB_len have no effect in BURST.
  - we in BURST: out <= MARB_in, go to IDLE, no done pulse (abort).
- rst in any state: out = 0, valid = 0, done = 0, state IDLE, beat counter = 0.

## Timing
- Reset values: MARB_out = 0, MARB_valid = 0, MARB_done = 0.
- Load and inc: MARB_out reflects the new value one cycle after the edge that samples them.
- Burst start:
  - start sampled at edge t: valid is high from t+1, and the first beat address equals MARB_out at t.
  - Minimum burst of N beats with ready held high: N cycles of valid, then done in the cycle after the last handshake, with valid low in that cycle.
- ready low stalls the burst: out and the counter hold, and valid stays high.
- done is never asserted in the same cycle as valid.
- Simultaneous start and we in IDLE: the load wins and the burst does not start.
- Simultaneous inc and start in IDLE: the burst starts and no increment is applied.
- rst mid-burst: the next cycle is IDLE with all outputs 0; no done pulse.
- back-to-back: a start sampled in the done cycle is accepted (state is IDLE).

## Test plan
- Reset and load:
  - Assert rst -> out = 0x0000, valid = 0, done = 0.
  - we with in = 0xA5A5 -> out = 0xA5A5, holding with we = 0.
- Wrap-around inc: load 0xFFFE, inc with stride = 3, mask = 0xFFFF -> out = 0x0001.
- Linear burst with stalls:
  - Load 0x00FE; start with len = 3, stride = 2, mask = 0xFFFF; ready toggling 1,0,1,1.
  - Required beats: 0x00FE, 0x0100 (held through the stall), 0x0102.
  - Then done pulses once and out = 0x0104.
- Wrap burst:
  - Load 0x123C; start with len = 4, stride = 4, mask = 0x000F; ready = 1.
  - Required beats: 0x123C, 0x1230, 0x1234, 0x1238.
  - Final out = 0x123C.
- Abort: during a len = 8 burst, assert we with in = 0x4000 after the 2nd beat -> out = 0x4000, valid = 0 next cycle, no done pulse.
- Mid-burst reset and ignored starts:
  - rst during a burst -> all outputs 0 the next cycle.
  - start with len = 0 -> stays IDLE, valid stays 0.
